// File: rtl/ahb_master.sv
// rtl/ahb_master.sv - single-outstanding AHB-style master transfer FSM
//
// Accepts one read or write request while idle, presents the registered
// address/data/direction on the bus, waits for hready, then pulses a
// one-cycle completion flag before returning to idle.
//
// Ports:
//   clk            in   1   rising-edge clock
//   n_rst          in   1   asynchronous reset, active high despite the name
//   hready         in   1   bus transfer-done, only observed in READ/WRITE
//   re / we        in   1   read / write request, only observed in IDLE
//   new_waddr      in  32   write address
//   new_raddr      in  32   read address
//   buffer2_data   in  32   write data source
//   sram_data      in  32   read data source
//   haddr          out 32   registered transfer address
//   hrdata         out 32   registered read data
//   hwdata         out 32   registered write data
//   hwrite         out  1   registered direction (1 = write)
//   read_complete  out  1   one-cycle read-done pulse
//   write_complete out  1   one-cycle write-done pulse

module ahb_master (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        hready,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] new_waddr,
  input  logic [31:0] new_raddr,
  input  logic [31:0] buffer2_data,
  input  logic [31:0] sram_data,
  output logic [31:0] haddr,
  output logic [31:0] hrdata,
  output logic [31:0] hwdata,
  output logic        hwrite,
  output logic        read_complete,
  output logic        write_complete
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ       = 3'd1,
    WRITE      = 3'd2,
    READ_DONE  = 3'd3,
    WRITE_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        hwrite_q, hwrite_d;
  logic        rc_q, rc_d;
  logic        wc_q, wc_d;

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q  <= IDLE;
      haddr_q  <= '0;
      hrdata_q <= '0;
      hwdata_q <= '0;
      hwrite_q <= 1'b0;
      rc_q     <= 1'b0;
      wc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hrdata_q <= hrdata_d;
      hwdata_q <= hwdata_d;
      hwrite_q <= hwrite_d;
      rc_q     <= rc_d;
      wc_q     <= wc_d;
    end
  end

  // Completion flags are registered on entry to the *_DONE state, so they
  // are high for exactly the one cycle spent in that state.
  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hrdata_d = hrdata_q;
    hwdata_d = hwdata_q;
    hwrite_d = hwrite_q;
    rc_d     = 1'b0;
    wc_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // Read wins when both requests are raised together.
        if (re) begin
          state_d  = READ;
          haddr_d  = new_raddr;
          hrdata_d = sram_data;
          hwrite_d = 1'b0;
        end else if (we) begin
          state_d  = WRITE;
          haddr_d  = new_waddr;
          hwdata_d = buffer2_data;
          hwrite_d = 1'b1;
        end
      end
      READ: begin
        if (hready) begin
          state_d = READ_DONE;
          rc_d    = 1'b1;
        end
      end
      WRITE: begin
        if (hready) begin
          state_d = WRITE_DONE;
          wc_d    = 1'b1;
        end
      end
      READ_DONE:  state_d = IDLE;
      WRITE_DONE: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  assign haddr          = haddr_q;
  assign hrdata         = hrdata_q;
  assign hwdata         = hwdata_q;
  assign hwrite         = hwrite_q;
  assign read_complete  = rc_q;
  assign write_complete = wc_q;

endmodule

// File: tb/tb_ahb_master.sv
// tb/tb_ahb_master.sv - directed self-checking bench for ahb_master

module tb_ahb_master;

  logic        clk;
  logic        n_rst;
  logic        hready;
  logic        re;
  logic        we;
  logic [31:0] new_waddr;
  logic [31:0] new_raddr;
  logic [31:0] buffer2_data;
  logic [31:0] sram_data;
  logic [31:0] haddr;
  logic [31:0] hrdata;
  logic [31:0] hwdata;
  logic        hwrite;
  logic        read_complete;
  logic        write_complete;

  int n_vec;
  int n_err;

  ahb_master dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .hready         (hready),
    .re             (re),
    .we             (we),
    .new_waddr      (new_waddr),
    .new_raddr      (new_raddr),
    .buffer2_data   (buffer2_data),
    .sram_data      (sram_data),
    .haddr          (haddr),
    .hrdata         (hrdata),
    .hwdata         (hwdata),
    .hwrite         (hwrite),
    .read_complete  (read_complete),
    .write_complete (write_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, want %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic rc, input logic wc);
    check({tag, ".rc"}, {31'd0, read_complete}, {31'd0, rc});
    check({tag, ".wc"}, {31'd0, write_complete}, {31'd0, wc});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".haddr"}, haddr, 32'h0);
    check({tag, ".hrdata"}, hrdata, 32'h0);
    check({tag, ".hwdata"}, hwdata, 32'h0);
    check({tag, ".hwrite"}, {31'd0, hwrite}, 32'h0);
    check_flags(tag, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    re = 1'b0;
    we = 1'b0;
    hready = 1'b0;
    n_rst = 1'b1;
    #1;
    step();
    n_rst = 1'b0;
    #1;
  endtask

  // Zero-wait write from IDLE; leaves the FSM back in IDLE.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    new_waddr = a;
    buffer2_data = d;
    we = 1'b1;
    step();
    we = 1'b0;
    buffer2_data = ~d;
    check("wr.haddr", haddr, a);
    check("wr.hwdata", hwdata, d);
    check("wr.hwrite", {31'd0, hwrite}, 32'd1);
    hready = 1'b1;
    step();
    hready = 1'b0;
    check_flags("wr.done", 1'b0, 1'b1);
    step();
    check("wr.hold", hwdata, d);
  endtask

  // Zero-wait read from IDLE; sram_data is changed after capture to prove hold.
  task automatic do_read(input logic [31:0] a, input logic [31:0] d);
    new_raddr = a;
    sram_data = d;
    re = 1'b1;
    step();
    re = 1'b0;
    sram_data = ~d;
    check("rd.haddr", haddr, a);
    check("rd.hrdata", hrdata, d);
    check("rd.hwrite", {31'd0, hwrite}, 32'd0);
    hready = 1'b1;
    step();
    hready = 1'b0;
    check_flags("rd.done", 1'b1, 1'b0);
    step();
    check("rd.hold", hrdata, d);
  endtask

  logic [31:0] pat [4];

  initial begin
    n_vec = 0;
    n_err = 0;
    new_waddr = '0;
    new_raddr = '0;
    buffer2_data = '0;
    sram_data = '0;
    pat[0] = 32'hFFFF_FFFF;
    pat[1] = 32'h0000_0000;
    pat[2] = 32'hAAAA_AAAA;
    pat[3] = 32'h5555_5555;

    // Reset state
    do_reset();
    check_all_zero("reset");

    // Write with one wait cycle
    new_waddr = 32'd2;
    buffer2_data = 32'hAAAA_AAAA;
    we = 1'b1;
    step();
    we = 1'b0;
    check("w1.haddr", haddr, 32'd2);
    check("w1.hwrite", {31'd0, hwrite}, 32'd1);
    check("w1.hwdata", hwdata, 32'hAAAA_AAAA);
    check_flags("w1.accept", 1'b0, 1'b0);
    // Request raised mid-transfer must be ignored.
    re = 1'b1;
    new_raddr = 32'h0000_00F0;
    step();
    re = 1'b0;
    check_flags("w1.wait", 1'b0, 1'b0);
    check("w1.ignore_re", haddr, 32'd2);
    hready = 1'b1;
    step();
    hready = 1'b0;
    check_flags("w1.done", 1'b0, 1'b1);
    step();
    check_flags("w1.idle", 1'b0, 1'b0);
    check("w1.hold_addr", haddr, 32'd2);

    // Read with no wait state
    new_raddr = 32'd3;
    sram_data = 32'h5555_5555;
    re = 1'b1;
    step();
    re = 1'b0;
    check("r1.haddr", haddr, 32'd3);
    check("r1.hwrite", {31'd0, hwrite}, 32'd0);
    check("r1.hrdata", hrdata, 32'h5555_5555);
    hready = 1'b1;
    step();
    hready = 1'b0;
    check_flags("r1.done", 1'b1, 1'b0);
    step();
    check_flags("r1.idle", 1'b0, 1'b0);

    // Spurious hready together with a read request
    do_reset();
    re = 1'b1;
    hready = 1'b1;
    new_raddr = 32'h10;
    step();
    re = 1'b0;
    hready = 1'b0;
    check_flags("spur.rd", 1'b0, 1'b0);
    hready = 1'b1;
    step();
    hready = 1'b0;
    check_flags("spur.rd_done", 1'b1, 1'b0);
    step();

    // Spurious hready together with a write request
    do_reset();
    we = 1'b1;
    hready = 1'b1;
    new_waddr = 32'h20;
    step();
    we = 1'b0;
    hready = 1'b0;
    check_flags("spur.wr", 1'b0, 1'b0);
    hready = 1'b1;
    step();
    hready = 1'b0;
    check_flags("spur.wr_done", 1'b0, 1'b1);
    step();

    // Simultaneous requests: read priority
    new_raddr = 32'h0000_1234;
    new_waddr = 32'h0000_5678;
    re = 1'b1;
    we = 1'b1;
    step();
    re = 1'b0;
    we = 1'b0;
    check("both.hwrite", {31'd0, hwrite}, 32'd0);
    check("both.haddr", haddr, 32'h0000_1234);
    hready = 1'b1;
    step();
    hready = 1'b0;
    check_flags("both.done", 1'b1, 1'b0);
    step();

    // Data/address sweep: writes then reads
    for (int i = 0; i < 4; i++) do_write(i, pat[i]);
    for (int i = 0; i < 4; i++) do_read(i, pat[3 - i]);

    // Reset asserted while in WRITE
    new_waddr = 32'hDEAD_BEEF;
    buffer2_data = 32'hCAFE_F00D;
    we = 1'b1;
    step();
    we = 1'b0;
    check("rstw.pre_haddr", haddr, 32'hDEAD_BEEF);
    #2;
    n_rst = 1'b1;
    #1;
    check_all_zero("rstw.async");
    hready = 1'b1;
    step();
    check_flags("rstw.no_done", 1'b0, 1'b0);
    n_rst = 1'b0;
    hready = 1'b0;
    #1;
    step();
    check_all_zero("rstw.after");

    // First edge after reset samples IDLE inputs normally
    new_raddr = 32'h0000_0042;
    sram_data = 32'h1357_9BDF;
    re = 1'b1;
    step();
    re = 1'b0;
    check("post.haddr", haddr, 32'h0000_0042);
    check("post.hrdata", hrdata, 32'h1357_9BDF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_master.md
AHB_MASTER -- requirements
Module: ahb_master

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; clk and n_rst are listed first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 n_rst  input  1  asynchronous reset; asserted when 1, ignoring the name's polarity prefix.
REQ-004 hready  input  1  bus transfer-done indication, sampled on clk rising edge.
REQ-005 re  input  1  read request, sampled in IDLE only.
REQ-006 we  input  1  write request, sampled in IDLE only.
REQ-007 new_waddr  input  32  write address.
REQ-008 new_raddr  input  32  read address.
REQ-009 buffer2_data  input  32  write data source.
REQ-010 sram_data  input  32  read data source.
REQ-011 haddr  output  32  registered transfer address.
REQ-012 hrdata  output  32  registered read data.
REQ-013 hwdata  output  32  registered write data.
REQ-014 hwrite  output  1  registered direction; 1 = write, 0 = read.
REQ-015 read_complete  output  1  registered one-cycle read-done pulse.
REQ-016 write_complete  output  1  registered one-cycle write-done pulse.

Function
REQ-017 The FSM SHALL have five states: IDLE, READ, WRITE, READ_DONE, WRITE_DONE.
REQ-018 In IDLE with re=1, next edge: go to READ; haddr<=new_raddr, hrdata<=sram_data, hwrite<=0.
REQ-019 In IDLE with we=1 and re=0, next edge: go to WRITE; haddr<=new_waddr, hwdata<=buffer2_data, hwrite<=1.
REQ-020 re=1 and we=1 together in IDLE SHALL be taken as a read (read priority); hwrite=0 afterwards.
REQ-021 hready SHALL be ignored in IDLE, READ_DONE and WRITE_DONE; it never causes a completion pulse from those states.
REQ-022 READ/WRITE SHALL hold while hready=0, with unlimited wait states.
REQ-023 READ with hready=1 SHALL go to READ_DONE; WRITE with hready=1 SHALL go to WRITE_DONE, both at the next edge.
REQ-024 READ_DONE and WRITE_DONE SHALL last exactly one cycle, then return to IDLE.
REQ-025 read_complete SHALL be 1 only in READ_DONE; write_complete SHALL be 1 only in WRITE_DONE; never both.
REQ-026 Latency: outputs are valid 1 cycle after re/we is sampled; the complete pulse is 1 cycle after hready is sampled high.
REQ-027 The minimum transaction is 3 cycles (accept, hready, done); the next request is accepted on the edge leaving IDLE, no earlier.
REQ-028 haddr, hwdata, hrdata and hwrite SHALL hold their last captured values until the next accepted request.
REQ-029 re/we asserted outside IDLE SHALL be ignored; there is no queueing.
REQ-030 Addresses and data SHALL pass through unmodified at full 32 bits, with no alignment or range checks.

Reset
REQ-031 n_rst=1 SHALL immediately force IDLE and zero haddr, hwdata, hrdata, hwrite, read_complete and write_complete.
REQ-032 Reset mid-transaction SHALL abort the transaction with no completion pulse.
REQ-033 After reset releases, the first edge SHALL sample IDLE inputs normally.

Verification
REQ-034 Write: new_waddr=2, buffer2_data=AAAAAAAA, we=1 for 1 cycle -> haddr=2, hwrite=1, hwdata=AAAAAAAA; 1 wait cycle then hready=1 -> write_complete=1 for one cycle.
REQ-035 Read: new_raddr=3, sram_data=55555555, re=1 -> haddr=3, hwrite=0, hrdata=55555555; hready=1 on the next cycle (no wait) -> read_complete=1 for one cycle.
REQ-036 Spurious hready: after reset, re=1 and hready=1 simultaneously -> next cycle read_complete=0 and write_complete=0; repeat with we=1 -> same.
REQ-037 Simultaneous re=1, we=1 from IDLE -> hwrite=0 and haddr=new_raddr.
REQ-038 Sweep data FFFFFFFF/00000000/AAAAAAAA/55555555 at addresses 0-3 for writes, then reads -> exact values on haddr, hwdata and hrdata each time.
REQ-039 Assert reset while in WRITE -> all outputs 0 at once; no write_complete.
